hist_cdf_gen: RTL and testbench
===============================

HIST_CDF_GEN -- requirements
Module: hist_cdf_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 20, giving the bin and cumulative counter width; it must cover the pixel count of one frame.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all logic.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port per_img_vsync, input, 1 bit: frame-valid, active high.
REQ-005 The block SHALL have port per_img_href, input, 1 bit: pixel-valid qualifier.
REQ-006 The block SHALL have port per_img_gray, input, 8 bits: pixel grey level.
REQ-007 The block SHALL have port pixel_level, output, 8 bits: grey level of the current CDF entry.
REQ-008 The block SHALL have port pixel_level_acc_num, output, CNT_W bits: cumulative count of pixels with grey <= pixel_level.
REQ-009 The block SHALL have port pixel_level_valid, output, 1 bit: CDF entry strobe.
REQ-010 The block SHALL have port hist_busy, output, 1 bit: high in INIT, DRAIN and SCAN.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last CDF entry.

Function
REQ-012 The block SHALL use an internal 256 x CNT_W histogram RAM with synchronous read (1-cycle latency), one read port and one write port.
REQ-013 The block SHALL implement states INIT, IDLE, ACCUM, DRAIN, SCAN and DONE.
REQ-014 INIT SHALL write zero to addresses 0..255 over 256 consecutive cycles, then go to IDLE.
REQ-015 IDLE SHALL go to ACCUM on a vsync rising edge (vsync high, previous sample low); a frame already in progress on entry to IDLE SHALL be ignored entirely.
REQ-016 ACCUM SHALL, for each cycle with href && vsync high, read bin[gray] and write bin[gray]+1 on the following cycle.
REQ-017 Back-to-back pixels of the same grey SHALL forward the pending increment so that no count is lost, including runs of any length.
REQ-018 ACCUM SHALL ignore href while vsync is low.
REQ-019 A vsync falling edge in ACCUM SHALL go to DRAIN for exactly 2 cycles, completing any in-flight write.
REQ-020 SCAN SHALL read addresses 0..255 in order, one per cycle, and write zero to each address the cycle it is read, clearing the histogram for the next frame.
REQ-021 In SCAN, pixel_level_valid SHALL assert 1 cycle after address 0 is issued and stay high for exactly 256 consecutive cycles with pixel_level = 0,1,...,255.
REQ-022 pixel_level_acc_num SHALL equal the running sum of bin[0..pixel_level], including the current bin.
REQ-023 The entry at level 255 SHALL equal the number of valid pixels in the frame.
REQ-024 The cycle after the level-255 entry, the block SHALL enter DONE and pulse frame_done for 1 cycle, then return to IDLE.
REQ-025 vsync/href activity during INIT, DRAIN, SCAN or DONE SHALL be ignored; a frame whose rising edge falls in those states SHALL not be counted.
REQ-026 pixel_level and pixel_level_acc_num SHALL hold their last value when valid is low.

Reset
REQ-027 Reset SHALL set pixel_level = 0, pixel_level_acc_num = 0, pixel_level_valid = 0, frame_done = 0 and the state to INIT, so hist_busy = 1 immediately.
REQ-028 Reset asserted mid-ACCUM or mid-SCAN SHALL abort the operation, emit no further valid, and re-run the full INIT clear.
REQ-029 RAM contents SHALL NOT be relied upon across reset.

Configuration
REQ-030 The macro HIST_CDF_SAT_EN SHALL select counter overflow behaviour.
REQ-031 With HIST_CDF_SAT_EN defined, bin increments and the cumulative sum SHALL saturate at 2^CNT_W-1.
REQ-032 Without HIST_CDF_SAT_EN, bin increments and the cumulative sum SHALL wrap modulo 2^CNT_W.

Verification
REQ-033 Reset release, then 256 cycles -> hist_busy high for 256 cycles, then low; no valid.
REQ-034 4x4 frame with all pixels = 10 (16 consecutive same-grey pixels) -> entries 0..9 have acc = 0; entries 10..255 have acc = 16; frame_done 1 cycle after level 255.
REQ-035 8x2 frame with greys 0..15 -> acc[k] = k+1 for k <= 15 and 16 for k > 15; a second identical frame gives identical output, proving the clear.
REQ-036 Frame rising edge during SCAN -> that frame is not counted; the next frame's CDF matches that frame alone.
REQ-037 CNT_W = 4, 20 pixels of grey 0 -> with HIST_CDF_SAT_EN, acc[0] = 15; without it, acc[0] = 4.
REQ-038 rst_n low at SCAN level 100 -> valid drops immediately; INIT repeats; the next frame's CDF is correct.

Source files
------------

// File: rtl/hist_cdf_gen.sv
// Purpose: per-frame grey-level histogram and cumulative distribution (CDF) generator; option macro HIST_CDF_SAT_EN saturates counters, otherwise they wrap.
// Latency: CDF scan starts 3 cycles after vsync falls; one entry per cycle for 256 cycles, frame_done one cycle after level 255.
// Backpressure: none; pixels outside a counted frame (or while busy) are dropped, consumer must take one entry per cycle.
module hist_cdf_gen #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_img_vsync,
    input  logic             per_img_href,
    input  logic [7:0]       per_img_gray,
    output logic [7:0]       pixel_level,
    output logic [CNT_W-1:0] pixel_level_acc_num,
    output logic             pixel_level_valid,
    output logic             hist_busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ACCUM, S_DRAIN, S_SCAN, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [8:0]       cnt;
    logic             vsync_d;

    logic             pix_vld, scan_issue;
    logic [7:0]       ram_raddr, ram_waddr;
    logic             ram_we;
    logic [CNT_W-1:0] ram_wdata, rd_data;
    logic [CNT_W-1:0] mem [0:255];

    logic             acc_vld;
    logic [7:0]       acc_gray;
    logic             fw_vld;
    logic [7:0]       fw_addr;
    logic [CNT_W-1:0] fw_data;
    logic [CNT_W-1:0] bin_base, bin_inc;

    logic             out_vld;
    logic [7:0]       out_level;
    logic [CNT_W-1:0] acc_hold, acc_prev, acc_sum;

    // State register, phase counter (restarts on every state change) and vsync history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_INIT;
            cnt     <= 9'd0;
            vsync_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state_nxt != state) ? 9'd0 : cnt + 9'd1;
            vsync_d <= per_img_vsync;
        end
    end

    // Next-state logic; only an IDLE rising edge opens a frame, so frames already running are skipped
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (cnt == 9'd255) state_nxt = S_IDLE;
            S_IDLE:  if (per_img_vsync && !vsync_d) state_nxt = S_ACCUM;
            S_ACCUM: if (!per_img_vsync && vsync_d) state_nxt = S_DRAIN;
            S_DRAIN: if (cnt == 9'd1) state_nxt = S_SCAN;
            S_SCAN:  if (cnt == 9'd256) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // RAM port steering: INIT and SCAN write zeros, otherwise the increment pipeline owns the write port
    always_comb begin
        pix_vld    = (state == S_ACCUM) && per_img_vsync && per_img_href;
        scan_issue = (state == S_SCAN) && !cnt[8];
        ram_raddr  = scan_issue ? cnt[7:0] : per_img_gray;
        ram_we     = 1'b0;
        ram_waddr  = cnt[7:0];
        ram_wdata  = '0;
        if (state == S_INIT || scan_issue) begin
            ram_we = 1'b1;
        end else if (acc_vld) begin
            ram_we    = 1'b1;
            ram_waddr = acc_gray;
            ram_wdata = bin_inc;
        end
    end

    // Histogram RAM: one synchronous read port (old data on read-during-write), one write port
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rd_data <= mem[ram_raddr];
    end

    // Increment: the read of a bin written on the previous cycle returns stale data, so forward the last write
    always_comb begin
        bin_base = (fw_vld && fw_addr == acc_gray) ? fw_data : rd_data;
`ifdef HIST_CDF_SAT_EN
        bin_inc  = (&bin_base) ? bin_base : bin_base + CNT_W'(1);
`else
        bin_inc  = bin_base + CNT_W'(1);
`endif
    end

    // Read-modify-write pipeline stage and forwarding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_vld  <= 1'b0;
            acc_gray <= 8'd0;
            fw_vld   <= 1'b0;
            fw_addr  <= 8'd0;
            fw_data  <= '0;
        end else begin
            acc_vld  <= pix_vld;
            acc_gray <= per_img_gray;
            fw_vld   <= acc_vld;
            fw_addr  <= acc_gray;
            fw_data  <= bin_inc;
        end
    end

    // Running sum: level 0 restarts the accumulation, bin data arrives straight from the RAM
    always_comb begin
        acc_prev = (out_level == 8'd0) ? '0 : acc_hold;
`ifdef HIST_CDF_SAT_EN
        acc_sum  = (acc_prev > ~rd_data) ? '1 : acc_prev + rd_data;
`else
        acc_sum  = acc_prev + rd_data;
`endif
    end

    // CDF output registers; level and sum hold between scans
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_level <= 8'd0;
            acc_hold  <= '0;
        end else begin
            out_vld <= scan_issue;
            if (scan_issue) out_level <= cnt[7:0];
            if (out_vld)    acc_hold  <= acc_sum;
        end
    end

    // Output mapping
    always_comb begin
        pixel_level         = out_level;
        pixel_level_acc_num = out_vld ? acc_sum : acc_hold;
        pixel_level_valid   = out_vld;
        hist_busy           = (state == S_INIT) || (state == S_DRAIN) || (state == S_SCAN);
        frame_done          = (state == S_DONE);
    end

endmodule

// File: tb/tb_hist_cdf_gen.sv
// Bench for hist_cdf_gen: two instances (20-bit and 4-bit counters) share one pixel stream.
// Expected CDFs come from a per-frame grey-count array folded with wrap or saturate arithmetic.
// Directed frames plus random frames, including activity during SCAN, a frame spanning IDLE entry and reset mid-scan.
module tb_hist_cdf_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  gray = 8'd0;

    logic [7:0]  lvl_a, lvl_b;
    logic [19:0] acc_a;
    logic [3:0]  acc_b;
    logic        vld_a, vld_b, busy_a, busy_b, done_a, done_b;

    int          tests = 0;
    int          fails = 0;
    int          cnt [256];
    logic [19:0] exp_a [256];
    logic [3:0]  exp_b [256];
    logic [7:0]  pix [$];

    hist_cdf_gen #(.CNT_W(20)) dut_a (
        .clk(clk), .rst_n(rst_n), .per_img_vsync(vsync), .per_img_href(href), .per_img_gray(gray),
        .pixel_level(lvl_a), .pixel_level_acc_num(acc_a), .pixel_level_valid(vld_a),
        .hist_busy(busy_a), .frame_done(done_a)
    );

    hist_cdf_gen #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .per_img_vsync(vsync), .per_img_href(href), .per_img_gray(gray),
        .pixel_level(lvl_b), .pixel_level_acc_num(acc_b), .pixel_level_valid(vld_b),
        .hist_busy(busy_b), .frame_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Add c pixels to a running total limited to a counter of size lim (= 2^W)
    function automatic longint fold(input longint acc, input longint c, input longint lim);
`ifdef HIST_CDF_SAT_EN
        longint b;
        b = (c > lim - 1) ? lim - 1 : c;
        return (acc + b > lim - 1) ? lim - 1 : acc + b;
`else
        return (acc + c) % lim;
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) cnt[i] = 0;
    endtask

    task automatic build_expect();
        longint ra = 0;
        longint rb = 0;
        for (int k = 0; k < 256; k++) begin
            ra = fold(ra, cnt[k], 1048576);
            rb = fold(rb, cnt[k], 16);
            exp_a[k] = ra[19:0];
            exp_b[k] = rb[3:0];
        end
    endtask

    // Random frame with frequent repeats so same-grey runs occur
    task automatic gen_rand();
        logic [7:0] p;
        int n;
        pix.delete();
        n = $urandom_range(30, 150);
        p = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) != 0) p = 8'($urandom);
            pix.push_back(p);
        end
    endtask

    // Drive one frame from pix; row_len>0 inserts a blank gap after each row
    task automatic send_frame(input int row_len, input bit rgaps);
        clear_model();
        @(negedge clk); href = 1'b1; gray = 8'($urandom);     // href without vsync: ignored
        @(negedge clk); href = 1'b0; vsync = 1'b1;
        repeat (2) begin @(negedge clk); gray = 8'($urandom); end
        for (int i = 0; i < pix.size(); i++) begin
            if (row_len > 0 && i > 0 && (i % row_len) == 0) begin
                @(negedge clk); href = 1'b0; gray = 8'($urandom);
                @(negedge clk);
            end
            if (rgaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk); href = 1'b0; gray = 8'($urandom);
            end
            @(negedge clk); href = 1'b1; gray = pix[i];
            cnt[pix[i]]++;
        end
        @(negedge clk); href = 1'b0;
        @(negedge clk); vsync = 1'b0;
    endtask

    // mode 0 plain, 1 new frame opened during SCAN, 2 vsync high from SCAN into IDLE, 3 reset at level 100
    task automatic do_scan(input int mode);
        int w = 0;
        build_expect();
        @(negedge clk);
        while (!vld_a && w < 40) begin w++; @(negedge clk); end
        check("scan_start_in_time", 32'(w < 40), 32'd1);
        for (int k = 0; k < 256; k++) begin
            check("valid_a", 32'(vld_a), 32'd1);
            check("valid_b", 32'(vld_b), 32'd1);
            check("level_a", 32'(lvl_a), 32'(k));
            check("level_b", 32'(lvl_b), 32'(k));
            check("acc_a", 32'(acc_a), 32'(exp_a[k]));
            check("acc_b", 32'(acc_b), 32'(exp_b[k]));
            if (mode == 3 && k == 100) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid_a", 32'(vld_a), 32'd0);
                check("abort_valid_b", 32'(vld_b), 32'd0);
                check("abort_busy", 32'(busy_a), 32'd1);
                return;
            end
            if (mode == 1) begin
                if (k == 40) vsync = 1'b1;
                if (k >= 50 && k < 90) begin href = 1'($urandom); gray = 8'($urandom); end
                if (k == 120) begin vsync = 1'b0; href = 1'b0; end
            end
            if (mode == 2 && k >= 200) begin
                vsync = 1'b1; href = 1'($urandom); gray = 8'($urandom);
            end
            @(negedge clk);
        end
        check("after_valid_a", 32'(vld_a), 32'd0);
        check("done_a", 32'(done_a), 32'd1);
        check("done_b", 32'(done_b), 32'd1);
        check("hold_level", 32'(lvl_a), 32'd255);
        check("hold_acc_a", 32'(acc_a), 32'(exp_a[255]));
        check("done_not_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("done_pulse_end", 32'(done_a), 32'd0);
        check("idle_not_busy", 32'(busy_a), 32'd0);
    endtask

    // Count INIT cycles after reset release; the release cycle is itself the first INIT cycle
    task automatic release_and_init();
        int n = 1;
        int vseen = 0;
        check("init_busy_at_release", 32'(busy_a), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (vld_a || vld_b) vseen++;
            if (!busy_a) break;
            n++;
        end
        check("init_cycles", 32'(n), 32'd256);
        check("init_no_valid", 32'(vseen), 32'd0);
        check("init_busy_b", 32'(busy_b), 32'd0);
    endtask

    initial begin
        int quiet;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd1);
        check("rst_valid", 32'(vld_a), 32'd0);
        check("rst_level", 32'(lvl_a), 32'd0);
        check("rst_acc", 32'(acc_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        release_and_init();

        // 4x4 frame of grey 10
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(8'd10);
        send_frame(4, 1'b0);
        do_scan(0);

        // two identical 8x2 frames of greys 0..15
        repeat (2) begin
            pix.delete();
            for (int i = 0; i < 16; i++) pix.push_back(8'(i));
            send_frame(8, 1'b0);
            do_scan(0);
        end

        // run of 20 grey-0 pixels: overflows the 4-bit instance
        pix.delete();
        for (int i = 0; i < 20; i++) pix.push_back(8'd0);
        send_frame(0, 1'b0);
        do_scan(0);

        // frame opened during SCAN must not leak into the next one
        gen_rand(); send_frame(0, 1'b1); do_scan(1);
        gen_rand(); send_frame(0, 1'b1); do_scan(0);

        // frame already running when IDLE is entered is ignored
        gen_rand(); send_frame(16, 1'b1); do_scan(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); href = 1'($urandom); gray = 8'($urandom);
        end
        @(negedge clk); vsync = 1'b0; href = 1'b0;
        quiet = 0;
        repeat (30) begin @(negedge clk); if (busy_a || vld_a) quiet++; end
        check("ignored_frame_quiet", 32'(quiet), 32'd0);
        gen_rand(); send_frame(0, 1'b1); do_scan(0);

        // reset in the middle of SCAN, then a clean frame
        gen_rand(); send_frame(0, 1'b1); do_scan(3);
        @(negedge clk);
        check("abort_still_invalid", 32'(vld_a), 32'd0);
        release_and_init();
        gen_rand(); send_frame(0, 1'b1); do_scan(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
